color_path_driver: RTL and testbench

COLOR_PATH_DRIVER -- requirements
Module: color_path_driver

---
 rtl/color_fsm_pkg.sv | 36 +++
 rtl/color_hop_planner.sv | 19 +
 rtl/color_path_driver.sv | 130 +++++++++++++
 tb/tb_color_path_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/color_fsm_pkg.sv
// Shared colour-FSM definitions: colour encoding, driver states, transition rule and LED expectation.
package color_fsm_pkg;
   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      BLUE   = 2'b01,
      PINK   = 2'b10,
      YELLOW = 2'b11
   } color_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PRESS = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } drv_state_t;

   localparam int CNT_W = 16;

   function automatic color_t color_next(input color_t s, input logic [1:0] sw);
      case (s)
         GREEN:   color_next = BLUE;
         BLUE:    color_next = sw[0] ? YELLOW : PINK;
         PINK:    color_next = sw[0] ? BLUE : GREEN;
         default: color_next = sw[1] ? YELLOW : GREEN;
      endcase
   endfunction

   function automatic logic [1:0] led_expect(input color_t s, input logic [1:0] sw);
      logic s1, s0;
      s1 = s[1];
      s0 = s[0];
      led_expect[0] = (!s1 & sw[0]) | !s0;
      led_expect[1] = (!s0 & sw[0]) | (!s1 & !sw[0]) | (s1 & s0 & sw[1]);
   endfunction
endpackage

// File: rtl/color_hop_planner.sv
// Shortest-path routing table: picks the switch setting for the next press and the resulting colour.
module color_hop_planner
   import color_fsm_pkg::*;
(
   input  color_t      cur_state,
   input  color_t      target,
   output logic [1:0]  sw,
   output color_t      next_state
);
   always_comb begin
      sw = 2'b00;
      case (cur_state)
         BLUE:    if (target == YELLOW) sw = 2'b01;
         PINK:    if (target == BLUE || target == YELLOW) sw = 2'b01;
         default: sw = 2'b00;
      endcase
      next_state = color_next(cur_state, sw);
   end
endmodule

// File: rtl/color_path_driver.sv
// Steers an external colour FSM to a target colour via timed button presses and switch setups.
// Optional LED cross-check against the modelled state is enabled with COLOR_DRV_VERIFY_EN.
module color_path_driver
   import color_fsm_pkg::*;
#(
   parameter int unsigned PRESS_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] target,
   input  logic       resync,
   input  logic [1:0] leds,
   output logic       btn,
   output logic [1:0] sw,
   output logic       busy,
   output logic       done,
   output logic [1:0] cur_state,
   output logic       mismatch
);
   localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   drv_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   color_t           cur_q, tgt_q, plan_tgt, plan_next;
   logic [1:0]       plan_sw;
   logic             accept, load_sw, step, check;

   // In IDLE the fresh request is planned directly; afterwards the latched target rules.
   assign plan_tgt = (state == IDLE) ? color_t'(target) : tgt_q;

   color_hop_planner u_planner (
      .cur_state  (cur_q),
      .target     (plan_tgt),
      .sw         (plan_sw),
      .next_state (plan_next)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_W'(1);
      accept  = 1'b0;
      load_sw = 1'b0;
      step    = 1'b0;
      check   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start && !resync) begin
               accept = 1'b1;
               if (color_t'(target) == cur_q) state_n = DONE;
               else begin
                  state_n = SETUP;
                  load_sw = 1'b1;
               end
            end
         end
         SETUP: if (cnt == GAP_LAST) begin
            state_n = PRESS;
            cnt_n   = '0;
         end
         PRESS: if (cnt == PRESS_LAST) begin
            state_n = GAP;
            cnt_n   = '0;
            step    = 1'b1;
         end
         GAP: if (cnt == GAP_LAST) begin
            check = 1'b1;
            cnt_n = '0;
            if (cur_q == tgt_q) state_n = DONE;
            else begin
               state_n = SETUP;
               load_sw = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cur_q <= GREEN;
         tgt_q <= GREEN;
         btn   <= 1'b0;
         sw    <= 2'b00;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         btn   <= (state_n == PRESS);
         done  <= (state == DONE);
         if (accept) begin
            busy  <= 1'b1;
            tgt_q <= color_t'(target);
         end else if (state == DONE) begin
            busy <= 1'b0;
         end
         if (load_sw) sw <= plan_sw;
         if (step) cur_q <= plan_next;
         else if (state == IDLE && resync) cur_q <= GREEN;
      end
   end

   assign cur_state = cur_q;

`ifdef COLOR_DRV_VERIFY_EN
   logic mismatch_q;
   always_ff @(posedge clk) begin
      if (rst) mismatch_q <= 1'b0;
      else if (check && leds != led_expect(cur_q, sw)) mismatch_q <= 1'b1;
   end
   assign mismatch = mismatch_q;
`else
   logic unused_inputs;
   assign unused_inputs = ^{leds, check};
   assign mismatch      = 1'b0;
`endif
endmodule

// File: tb/tb_color_path_driver.sv
// Randomized self-checking bench: a shortest-path search over the colour rules predicts each transaction.
module tb_color_path_driver;
   localparam int P   = 3;
   localparam int G   = 2;
   localparam int HOP = 2 * G + P;

   logic       clk = 1'b0;
   logic       rst, start, resync;
   logic [1:0] target, leds;
   logic       btn, busy, done, mismatch;
   logic [1:0] sw, cur_state;

   int checks = 0;
   int errors = 0;

   // external colour FSM stand-in, advancing on each button rising edge
   logic [1:0] col = 2'b00;
   logic       btn_d = 1'b0;
   logic       col_rst, leds_bad;
   logic [1:0] exp_cur;
   logic       exp_mm;

   color_path_driver #(.PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .target    (target),
      .resync    (resync),
      .leds      (leds),
      .btn       (btn),
      .sw        (sw),
      .busy      (busy),
      .done      (done),
      .cur_state (cur_state),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] col_step(input logic [1:0] s, input logic [1:0] w);
      case (s)
         2'd0:    return 2'd1;
         2'd1:    return w[0] ? 2'd3 : 2'd2;
         2'd2:    return w[0] ? 2'd1 : 2'd0;
         default: return w[1] ? 2'd3 : 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] led_tab(input logic [1:0] s, input logic [1:0] w);
      case (s)
         2'd0:    return 2'b11;
         2'd1:    return w[0] ? 2'b01 : 2'b10;
         2'd2:    return w[0] ? 2'b11 : 2'b01;
         default: return w[1] ? 2'b10 : 2'b00;
      endcase
   endfunction

   always @(posedge clk) begin
      if (col_rst) col <= 2'b00;
      else if (btn && !btn_d) col <= col_step(col, sw);
      btn_d <= btn;
   end

   assign leds = leds_bad ? 2'b00 : led_tab(col, sw);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Iterative deepening over sw0 choices, 00 preferred at earlier hops.
   task automatic plan(input logic [1:0] s, input logic [1:0] t, output int n, output logic [2:0] seq);
      logic [1:0] st;
      n   = 0;
      seq = 3'b000;
      if (s != t) begin
         for (int d = 1; d <= 3; d++) begin
            for (int m = 0; m < (1 << d); m++) begin
               if (n == 0) begin
                  st = s;
                  for (int i = 0; i < d; i++) st = col_step(st, {1'b0, m[d-1-i]});
                  if (st == t) begin
                     n = d;
                     for (int i = 0; i < d; i++) seq[i] = m[d-1-i];
                  end
               end
            end
         end
      end
   endtask

   task automatic run_txn(input logic [1:0] t, input bit poke);
      int n, L, k, hops, btn_cnt;
      logic [2:0] seq;
      logic prev;
      plan(exp_cur, t, n, seq);
      L = (n == 0) ? 2 : n * HOP + 2;
      @(negedge clk);
      start  = 1'b1;
      target = t;
      @(negedge clk);
      start   = 1'b0;
      target  = 2'($urandom);
      k       = 1;
      hops    = 0;
      btn_cnt = 0;
      prev    = 1'b0;
      while (!done && k < L + 20) begin
         chk("busy_run", 32'(busy), 32'd1);
         if (btn) begin
            btn_cnt++;
            if (!prev) hops++;
            if (hops >= 1 && hops <= 3) chk("hop_sw", 32'(sw), 32'({1'b0, seq[hops-1]}));
         end
         prev  = btn;
         start = (poke && k == 3);
         if (start) target = 2'($urandom);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk("done_lat", 32'(k), 32'(L));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("press_count", 32'(hops), 32'(n));
      chk("btn_cycles", 32'(btn_cnt), 32'(n * P));
      chk("cur_state", 32'(cur_state), 32'(t));
      if (n > 0) chk("sw_idle", 32'(sw), 32'({1'b0, seq[n-1]}));
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("mismatch", 32'(mismatch), 32'(exp_mm));
      exp_cur = t;
   endtask

   initial begin
      int w, dcnt;
      rst      = 1'b1;
      start    = 1'b0;
      resync   = 1'b0;
      target   = 2'b00;
      col_rst  = 1'b1;
      leds_bad = 1'b0;
      exp_cur  = 2'b00;
      exp_mm   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_btn", 32'(btn), 32'd0);
      chk("rst_sw", 32'(sw), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cur", 32'(cur_state), 32'd0);
      chk("rst_mismatch", 32'(mismatch), 32'd0);
      rst     = 1'b0;
      col_rst = 1'b0;

      // directed paths: GREEN->PINK, PINK->YELLOW, YELLOW->PINK, then an equal target
      run_txn(2'b10, 1'b1);
      run_txn(2'b11, 1'b0);
      run_txn(2'b10, 1'b1);
      run_txn(2'b10, 1'b0);

      // resync wins over a simultaneous start
      @(negedge clk);
      resync  = 1'b1;
      start   = 1'b1;
      target  = 2'b01;
      col_rst = 1'b1;
      @(negedge clk);
      resync  = 1'b0;
      start   = 1'b0;
      col_rst = 1'b0;
      chk("resync_cur", 32'(cur_state), 32'd0);
      chk("resync_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("resync_busy2", 32'(busy), 32'd0);
      exp_cur = 2'b00;

      repeat (16) run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      // reset in the 2nd PRESS cycle aborts the path
      @(negedge clk);
      start  = 1'b1;
      target = exp_cur ^ 2'b10;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!btn && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("abort_reach_press", 32'(btn), 32'd1);
      @(negedge clk);
      rst     = 1'b1;
      col_rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      col_rst = 1'b0;
      chk("abort_btn", 32'(btn), 32'd0);
      chk("abort_cur", 32'(cur_state), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      dcnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      exp_cur = 2'b00;

`ifdef COLOR_DRV_VERIFY_EN
      run_txn(2'b10, 1'b0);
      leds_bad = 1'b1;
      exp_mm   = 1'b1;
      run_txn(2'b01, 1'b0);
      leds_bad = 1'b0;
      run_txn(2'b00, 1'b0);
      @(negedge clk);
      rst     = 1'b1;
      col_rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      col_rst = 1'b0;
      chk("mismatch_cleared", 32'(mismatch), 32'd0);
      exp_mm  = 1'b0;
      exp_cur = 2'b00;
`endif

      run_txn(2'b11, 1'b1);
      run_txn(2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
